matrix_output: RTL and testbench
================================

MATRIX_OUTPUT -- requirements
Module: matrix_output

Interface
REQ-001 SHALL have parameter MAX_DIM, default 5: maximum row and column count.
REQ-002 SHALL have parameter DW, default 4: element width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: 1-cycle request to transmit the matrix.
REQ-006 SHALL have port mat_m, input, 4 bits: row count.
REQ-007 SHALL have port mat_n, input, 4 bits: column count.
REQ-008 SHALL have port mat_data, input, MAX_DIM*MAX_DIM*DW bits: element (i,j) occupies bits [(i*MAX_DIM+j)*DW +: DW].
REQ-009 SHALL have port tx_busy, input, 1 bit: the UART transmitter is sending a byte.
REQ-010 SHALL have port tx_data, output, 8 bits: byte to transmit.
REQ-011 SHALL have port tx_start, output, 1 bit: 1-cycle send strobe to the UART.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have port output_done, output, 1 bit: 1-cycle completion pulse.
REQ-014 SHALL have port error_type, output, 3 bits: 000 = no error, 001 = dimension error.

Function
REQ-015 SHALL capture mat_m, mat_n and mat_data on the cycle start is sampled in IDLE; later input changes SHALL NOT affect an ongoing transfer.
REQ-016 SHALL ignore start while busy is high.
REQ-017 SHALL check the captured dimensions in CHECK, one cycle after start.
- If mat_m or mat_n is outside 1..MAX_DIM: go to DONE with error_type = 001 and send no bytes.
- Otherwise: clear error_type to 000.
REQ-018 SHALL implement states IDLE, CHECK, LOAD, STROBE, WAIT_ACK, WAIT_FREE and DONE.
- LOAD selects the next byte and moves to STROBE.
- STROBE pulses tx_start for one cycle, with tx_data valid in that same cycle.
- WAIT_ACK waits until tx_busy = 1.
- WAIT_FREE waits until tx_busy = 0, then goes to LOAD, or to DONE after the last byte.
- DONE pulses output_done for one cycle and returns to IDLE.
REQ-019 SHALL enter STROBE only when tx_busy = 0; if tx_busy is high on entry to LOAD, it SHALL stay in LOAD.
REQ-020 SHALL hold tx_data stable from STROBE until tx_busy falls.
REQ-021 SHALL send the byte sequence m, n, then elements in row-major order.
REQ-022 SHALL encode every dimension and element value v as 8'h30 | {4'h0, v}.
- This maps 0..9 to '0'..'9' and 10..15 to ':'..'?'.
- It is the inverse of the receiver's low-nibble decode.
REQ-023 SHALL track position with a row counter (0..mat_m-1) and a column counter (0..mat_n-1).
- The column wraps to 0 and the row increments after column mat_n-1.
- The last byte is the element at (mat_m-1, mat_n-1).
REQ-024 SHALL hold output_done at 0 except in the DONE cycle.
REQ-025 SHALL hold tx_start at 0 outside STROBE.

Reset
REQ-026 SHALL, on rst, set tx_start = 0, tx_data = 8'h00, busy = 0, output_done = 0 and error_type = 000, clear all counters and captured data, and go to IDLE.
REQ-027 SHALL, on rst during a transfer, abort it immediately with no output_done pulse; the next start SHALL begin a fresh sequence.

Configuration
REQ-028 SHALL, with MATRIX_OUTPUT_FORMAT_EN defined, send a human-readable frame:
- m, n, CR (8'h0D), LF (8'h0A);
- then each row, with one space (8'h20) between elements and CR, LF after the last element.
- Total bytes: 4 + m*(2n+1).
REQ-029 SHALL, without MATRIX_OUTPUT_FORMAT_EN, send only the raw stream of REQ-021 (2 + m*n bytes), byte-compatible with matrix_input.

Structure
REQ-030 SHALL take from the shared package matrix_pkg:
- MAX_DIM;
- the error codes ERR_NONE = 3'b000 and ERR_DIM = 3'b001;
- the ASCII constants for '0' base, space, CR and LF.
REQ-031 SHALL keep the state encoding local to the module.
REQ-032 SHALL be a single module with no sub-modules; byte selection is in-module combinational logic.

Verification
REQ-033 SHALL pass: 2x3 with elements 1..6, raw build, a UART model that asserts tx_busy 1 cycle after tx_start for 10 cycles.
- Expect 8 bytes: 32 33 31 32 33 34 35 36.
- Expect output_done once and error_type = 000.
REQ-034 SHALL pass: the same stimulus with MATRIX_OUTPUT_FORMAT_EN defined.
- Expect 18 bytes: 32 33 0D 0A 31 20 32 20 33 0D 0A 34 20 35 20 36 0D 0A.
REQ-035 SHALL pass: mat_m = 6, mat_n = 2.
- Expect zero tx_start pulses, error_type = 001, and output_done 2 cycles after start.
REQ-036 SHALL pass: 5x5 with all elements 15 (max size, max value).
- Expect 27 bytes of which 25 are 8'h3F.
- Expect the column counter to wrap correctly on all 5 rows.
REQ-037 SHALL pass: a second start and changes to mat_data during a transfer.
- Expect both to be ignored and the bytes to match the captured matrix.
REQ-038 SHALL pass: rst asserted after the 3rd byte.
- Expect tx_start = 0, busy = 0 and no output_done.
- A new start then sends the full sequence from m.

Source files
------------

// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module : matrix_pkg
// Brief  : Shared matrix sizes, error codes, ASCII constants and byte kinds.
// Rev    : 1.0  initial release
// ============================================================================
package matrix_pkg;

    localparam int MAX_DIM = 5;

    localparam logic [2:0] ERR_NONE = 3'b000;
    localparam logic [2:0] ERR_DIM  = 3'b001;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Kind of the byte currently being sent; HCR/HLF terminate the header line.
    typedef enum logic [2:0] {
        ITEM_M    = 3'd0,
        ITEM_N    = 3'd1,
        ITEM_HCR  = 3'd2,
        ITEM_HLF  = 3'd3,
        ITEM_ELEM = 3'd4,
        ITEM_SP   = 3'd5,
        ITEM_CR   = 3'd6,
        ITEM_LF   = 3'd7
    } item_e;

    function automatic logic [7:0] ascii_nibble(input logic [3:0] v);
        return ASCII_ZERO | {4'h0, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_output_if.sv
`default_nettype none
// ============================================================================
// Module : matrix_output_if
// Brief  : Request, matrix and UART-side signal bundle of matrix_output.
// Rev    : 1.0  initial release
// ============================================================================
interface matrix_output_if #(
    parameter int MAX_DIM = 5,
    parameter int DW      = 4
);
    logic                         start;
    logic [3:0]                   mat_m;
    logic [3:0]                   mat_n;
    logic [MAX_DIM*MAX_DIM*DW-1:0] mat_data;
    logic                         tx_busy;
    logic [7:0]                   tx_data;
    logic                         tx_start;
    logic                         busy;
    logic                         output_done;
    logic [2:0]                   error_type;

    modport master (
        output start, mat_m, mat_n, mat_data, tx_busy,
        input  tx_data, tx_start, busy, output_done, error_type
    );

    modport slave (
        input  start, mat_m, mat_n, mat_data, tx_busy,
        output tx_data, tx_start, busy, output_done, error_type
    );
endinterface
`default_nettype wire

// File: rtl/matrix_output.sv
`default_nettype none
// ============================================================================
// Module : matrix_output
// Brief  : Streams a captured matrix to a UART transmitter as ASCII bytes.
//          MATRIX_OUTPUT_FORMAT_EN selects the human-readable framed output.
// Rev    : 1.0  initial release
// ============================================================================
module matrix_output #(
    parameter int MAX_DIM = matrix_pkg::MAX_DIM,
    parameter int DW      = 4
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          start,
    input  wire logic [3:0]                    mat_m,
    input  wire logic [3:0]                    mat_n,
    input  wire logic [MAX_DIM*MAX_DIM*DW-1:0] mat_data,
    input  wire logic                          tx_busy,
    output logic [7:0]                         tx_data,
    output logic                               tx_start,
    output logic                               busy,
    output logic                               output_done,
    output logic [2:0]                         error_type
);
    import matrix_pkg::*;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CHECK     = 3'd1;
    localparam logic [2:0] S_LOAD      = 3'd2;
    localparam logic [2:0] S_STROBE    = 3'd3;
    localparam logic [2:0] S_WAIT_ACK  = 3'd4;
    localparam logic [2:0] S_WAIT_FREE = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    localparam logic [3:0] C_MAX_DIM = 4'(MAX_DIM);

    logic [2:0]                    r_state;
    logic [3:0]                    r_m;
    logic [3:0]                    r_n;
    logic [MAX_DIM*MAX_DIM*DW-1:0] r_data;
    logic [3:0]                    r_row;
    logic [3:0]                    r_col;
    item_e                         r_item;
    logic [7:0]                    r_tx_data;
    logic [2:0]                    r_err;

    int                            w_cell;
    logic [DW-1:0]                 w_elem;
    logic [3:0]                    w_elem_nib;
    logic [7:0]                    w_byte;
    logic                          w_col_last;
    logic                          w_row_last;
    logic                          w_last;
    logic                          w_dim_bad;
    item_e                         w_next_item;
    logic [3:0]                    w_next_row;
    logic [3:0]                    w_next_col;

    assign w_col_last = (r_col == r_n - 4'd1);
    assign w_row_last = (r_row == r_m - 4'd1);
    assign w_dim_bad  = (r_m == 4'd0) || (r_m > C_MAX_DIM) ||
                        (r_n == 4'd0) || (r_n > C_MAX_DIM);

`ifdef MATRIX_OUTPUT_FORMAT_EN
    assign w_last = (r_item == ITEM_LF) && w_row_last;
`else
    assign w_last = (r_item == ITEM_ELEM) && w_row_last && w_col_last;
`endif

    always_comb begin
        w_cell = int'(r_row) * MAX_DIM + int'(r_col);
        w_elem = r_data[w_cell*DW +: DW];
        // Encoding only carries the low nibble of each element.
        w_elem_nib = 4'h0;
        for (int b = 0; b < DW && b < 4; b++) begin
            w_elem_nib[b] = w_elem[b];
        end
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_item)
            ITEM_M:    w_byte = ascii_nibble(r_m);
            ITEM_N:    w_byte = ascii_nibble(r_n);
            ITEM_ELEM: w_byte = ascii_nibble(w_elem_nib);
            ITEM_SP:   w_byte = ASCII_SPACE;
            ITEM_HCR,
            ITEM_CR:   w_byte = ASCII_CR;
            ITEM_HLF,
            ITEM_LF:   w_byte = ASCII_LF;
            default:   w_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_next_item = r_item;
        w_next_row  = r_row;
        w_next_col  = r_col;
        case (r_item)
            ITEM_M: w_next_item = ITEM_N;
`ifdef MATRIX_OUTPUT_FORMAT_EN
            ITEM_N:    w_next_item = ITEM_HCR;
            ITEM_HCR:  w_next_item = ITEM_HLF;
            ITEM_HLF:  w_next_item = ITEM_ELEM;
            ITEM_ELEM: w_next_item = w_col_last ? ITEM_CR : ITEM_SP;
            ITEM_SP: begin
                w_next_item = ITEM_ELEM;
                w_next_col  = r_col + 4'd1;
            end
            ITEM_CR: w_next_item = ITEM_LF;
            ITEM_LF: begin
                w_next_item = ITEM_ELEM;
                w_next_row  = r_row + 4'd1;
                w_next_col  = 4'd0;
            end
`else
            ITEM_N: w_next_item = ITEM_ELEM;
            ITEM_ELEM: begin
                if (w_col_last) begin
                    w_next_row = r_row + 4'd1;
                    w_next_col = 4'd0;
                end else begin
                    w_next_col = r_col + 4'd1;
                end
            end
`endif
            default: w_next_item = r_item;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_m       <= 4'd0;
            r_n       <= 4'd0;
            r_data    <= '0;
            r_row     <= 4'd0;
            r_col     <= 4'd0;
            r_item    <= ITEM_M;
            r_tx_data <= 8'h00;
            r_err     <= ERR_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m     <= mat_m;
                        r_n     <= mat_n;
                        r_data  <= mat_data;
                        r_row   <= 4'd0;
                        r_col   <= 4'd0;
                        r_item  <= ITEM_M;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_dim_bad) begin
                        r_err   <= ERR_DIM;
                        r_state <= S_DONE;
                    end else begin
                        r_err   <= ERR_NONE;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!tx_busy) begin
                        r_tx_data <= w_byte;
                        r_state   <= S_STROBE;
                    end
                end
                S_STROBE:   r_state <= S_WAIT_ACK;
                S_WAIT_ACK: if (tx_busy) r_state <= S_WAIT_FREE;
                S_WAIT_FREE: begin
                    if (!tx_busy) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_item  <= w_next_item;
                            r_row   <= w_next_row;
                            r_col   <= w_next_col;
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_start    = (r_state == S_STROBE);
    assign busy        = (r_state != S_IDLE);
    assign output_done = (r_state == S_DONE);
    assign error_type  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_matrix_output.sv
`default_nettype none
// ============================================================================
// Module : tb_matrix_output
// Brief  : Self-checking bench for matrix_output with a reactive UART model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_matrix_output;
    import matrix_pkg::*;

    localparam int MD    = 5;
    localparam int DW    = 4;
    localparam int CELLS = MD * MD;
    localparam int BUDGET = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_output_if #(.MAX_DIM(MD), .DW(DW)) mif ();

    logic uart_busy, uart_pend, ext_busy;
    int   uart_cnt;
    int   busy_len;
    assign mif.tx_busy = uart_busy | ext_busy;

    matrix_output #(.MAX_DIM(MD), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (mif.start),
        .mat_m      (mif.mat_m),
        .mat_n      (mif.mat_n),
        .mat_data   (mif.mat_data),
        .tx_busy    (mif.tx_busy),
        .tx_data    (mif.tx_data),
        .tx_start   (mif.tx_start),
        .busy       (mif.busy),
        .output_done(mif.output_done),
        .error_type (mif.error_type)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         start_cnt, done_cnt, stab_err;
    logic [7:0] last_byte = 8'h00;

    // UART: busy one cycle after the strobe, for busy_len cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_busy <= 1'b0;
            uart_pend <= 1'b0;
            uart_cnt  <= 0;
        end else begin
            if (mif.tx_start) uart_pend <= 1'b1;
            if (uart_pend) begin
                uart_pend <= 1'b0;
                uart_busy <= 1'b1;
                uart_cnt  <= busy_len - 1;
            end else if (uart_busy) begin
                if (uart_cnt == 0) uart_busy <= 1'b0;
                else               uart_cnt  <= uart_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mif.tx_start) begin
            rx_q.push_back(mif.tx_data);
            last_byte = mif.tx_data;
            start_cnt++;
        end else if (mif.tx_busy && mif.tx_data !== last_byte) begin
            stab_err++;
        end
        if (mif.output_done) done_cnt++;
    end

    // Reference: byte stream derived directly from dimensions and elements.
    task automatic build_model(input int m, input int n, input logic [CELLS*DW-1:0] d);
        exp_q.delete();
        exp_q.push_back(8'h30 + 8'(m));
        exp_q.push_back(8'h30 + 8'(n));
`ifdef MATRIX_OUTPUT_FORMAT_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < n; j++) begin
                logic [DW-1:0] v;
                v = d[(i*MD+j)*DW +: DW];
                exp_q.push_back(8'h30 + 8'(v));
`ifdef MATRIX_OUTPUT_FORMAT_EN
                if (j < n - 1) exp_q.push_back(8'h20);
`endif
            end
`ifdef MATRIX_OUTPUT_FORMAT_EN
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
`endif
        end
    endtask

    task automatic clear_obs();
        rx_q.delete();
        start_cnt = 0;
        done_cnt  = 0;
        stab_err  = 0;
    endtask

    task automatic do_start(input int m, input int n, input logic [CELLS*DW-1:0] d);
        @(negedge clk);
        mif.mat_m    = 4'(m);
        mif.mat_n    = 4'(n);
        mif.mat_data = d;
        mif.start    = 1'b1;
        @(negedge clk);
        mif.start    = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (mif.output_done) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        #1;
    endtask

    function automatic logic [CELLS*DW-1:0] rand_matrix();
        logic [CELLS*DW-1:0] d;
        for (int k = 0; k < CELLS; k++) d[k*DW +: DW] = DW'($urandom_range(0, 15));
        return d;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (mif.tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b want=0", mif.tx_start); end
        checks++; if (mif.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h want=00", mif.tx_data); end
        checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", mif.busy); end
        checks++; if (mif.output_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", mif.output_done); end
        checks++; if (mif.error_type !== 3'b000) begin errors++; $display("FAIL reset_err got=%b want=000", mif.error_type); end
    endtask

    task automatic test_known_2x3();
        logic [CELLS*DW-1:0] d;
        logic [7:0]          lit[$];
        bit                  ok;
        d = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++) d[(i*MD+j)*DW +: DW] = DW'(i*3 + j + 1);
`ifdef MATRIX_OUTPUT_FORMAT_EN
        lit = '{8'h32, 8'h33, 8'h0D, 8'h0A, 8'h31, 8'h20, 8'h32, 8'h20, 8'h33,
                8'h0D, 8'h0A, 8'h34, 8'h20, 8'h35, 8'h20, 8'h36, 8'h0D, 8'h0A};
`else
        lit = '{8'h32, 8'h33, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
`endif
        busy_len = 10;
        clear_obs();
        build_model(2, 3, d);
        do_start(2, 3, d);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL known_timeout got=no_done want=done"); end
        checks++; if (rx_q != lit) begin errors++; $display("FAIL known_bytes got=%p want=%p", rx_q, lit); end
        checks++; if (rx_q != exp_q) begin errors++; $display("FAIL known_model got=%p want=%p", rx_q, exp_q); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL known_done_cnt got=%0d want=1", done_cnt); end
        checks++; if (mif.error_type !== ERR_NONE) begin errors++; $display("FAIL known_err got=%b want=000", mif.error_type); end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL known_stable got=%0d want=0", stab_err); end
    endtask

    task automatic test_dim_error();
        int dims[3][2] = '{'{6, 2}, '{0, 3}, '{3, 6}};
        for (int t = 0; t < 3; t++) begin
            clear_obs();
            @(negedge clk);
            mif.mat_m = 4'(dims[t][0]);
            mif.mat_n = 4'(dims[t][1]);
            mif.start = 1'b1;
            @(negedge clk);
            mif.start = 1'b0;
            checks++; if (mif.output_done !== 1'b0) begin errors++; $display("FAIL dim_early_done case=%0d got=%b want=0", t, mif.output_done); end
            @(negedge clk);
            checks++; if (mif.output_done !== 1'b1) begin errors++; $display("FAIL dim_done_at_2 case=%0d got=%b want=1", t, mif.output_done); end
            @(negedge clk);
            #1;
            checks++; if (mif.error_type !== ERR_DIM) begin errors++; $display("FAIL dim_err case=%0d got=%b want=001", t, mif.error_type); end
            checks++; if (start_cnt !== 0) begin errors++; $display("FAIL dim_no_tx case=%0d got=%0d want=0", t, start_cnt); end
            checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL dim_busy case=%0d got=%b want=0", t, mif.busy); end
        end
    endtask

    task automatic test_max_size();
        logic [CELLS*DW-1:0] d;
        int                  n3f;
        bit                  ok;
        d = '1;
        busy_len = 3;
        clear_obs();
        build_model(5, 5, d);
        do_start(5, 5, d);
        wait_done(ok);
        n3f = 0;
        foreach (rx_q[k]) if (rx_q[k] == 8'h3F) n3f++;
        checks++; if (!ok) begin errors++; $display("FAIL max_timeout got=no_done want=done"); end
`ifdef MATRIX_OUTPUT_FORMAT_EN
        checks++; if (rx_q.size() !== 59) begin errors++; $display("FAIL max_count got=%0d want=59", rx_q.size()); end
`else
        checks++; if (rx_q.size() !== 27) begin errors++; $display("FAIL max_count got=%0d want=27", rx_q.size()); end
`endif
        checks++; if (n3f !== 25) begin errors++; $display("FAIL max_3f got=%0d want=25", n3f); end
        checks++; if (rx_q != exp_q) begin errors++; $display("FAIL max_model got=%p want=%p", rx_q, exp_q); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int                  m, n;
            logic [CELLS*DW-1:0] d;
            bit                  ok;
            m = $urandom_range(1, 5);
            n = $urandom_range(1, 5);
            d = rand_matrix();
            busy_len = $urandom_range(1, 12);
            clear_obs();
            build_model(m, n, d);
            do_start(m, n, d);
            wait_done(ok);
            checks++; if (!ok || rx_q != exp_q) begin errors++; $display("FAIL rand_bytes iter=%0d m=%0d n=%0d got=%p want=%p", t, m, n, rx_q, exp_q); end
            checks++; if (mif.error_type !== ERR_NONE || done_cnt !== 1) begin errors++; $display("FAIL rand_status iter=%0d got=err%b/done%0d want=err000/done1", t, mif.error_type, done_cnt); end
        end
    endtask

    task automatic test_ignore_during_busy();
        logic [CELLS*DW-1:0] d;
        bit                  ok;
        d = rand_matrix();
        busy_len = 4;
        clear_obs();
        build_model(3, 4, d);
        do_start(3, 4, d);
        for (int c = 0; c < BUDGET && start_cnt < 2; c++) @(negedge clk);
        mif.mat_data = ~d;
        mif.mat_m    = 4'd1;
        mif.mat_n    = 4'd2;
        mif.start    = 1'b1;
        @(negedge clk);
        mif.start    = 1'b0;
        wait_done(ok);
        checks++; if (!ok || rx_q != exp_q) begin errors++; $display("FAIL ignore_bytes got=%p want=%p", rx_q, exp_q); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ignore_done_cnt got=%0d want=1", done_cnt); end
        repeat (5) @(negedge clk);
        checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL ignore_restart got=busy%b want=0", mif.busy); end
    endtask

    task automatic test_reset_abort();
        logic [CELLS*DW-1:0] d;
        bit                  ok;
        d = rand_matrix();
        busy_len = 5;
        clear_obs();
        do_start(3, 3, d);
        for (int c = 0; c < BUDGET && start_cnt < 3; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mif.tx_start !== 1'b0 || mif.busy !== 1'b0) begin errors++; $display("FAIL abort_outputs got=start%b/busy%b want=0/0", mif.tx_start, mif.busy); end
        checks++; if (mif.tx_data !== 8'h00) begin errors++; $display("FAIL abort_tx_data got=%h want=00", mif.tx_data); end
        rst = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done got=%0d want=0", done_cnt); end
        d = rand_matrix();
        clear_obs();
        build_model(2, 2, d);
        do_start(2, 2, d);
        wait_done(ok);
        checks++; if (!ok || rx_q != exp_q) begin errors++; $display("FAIL abort_fresh got=%p want=%p", rx_q, exp_q); end
    endtask

    task automatic test_load_stall();
        logic [CELLS*DW-1:0] d;
        bit                  ok;
        d = rand_matrix();
        busy_len = 2;
        clear_obs();
        build_model(2, 2, d);
        ext_busy = 1'b1;
        do_start(2, 2, d);
        repeat (15) @(negedge clk);
        checks++; if (start_cnt !== 0 || mif.busy !== 1'b1) begin errors++; $display("FAIL stall_hold got=starts%0d/busy%b want=0/1", start_cnt, mif.busy); end
        ext_busy = 1'b0;
        wait_done(ok);
        checks++; if (!ok || rx_q != exp_q) begin errors++; $display("FAIL stall_bytes got=%p want=%p", rx_q, exp_q); end
    endtask

    initial begin
        rst          = 1'b1;
        ext_busy     = 1'b0;
        busy_len     = 10;
        mif.start    = 1'b0;
        mif.mat_m    = 4'd0;
        mif.mat_n    = 4'd0;
        mif.mat_data = '0;
        clear_obs();
        test_reset();
        test_known_2x3();
        test_dim_error();
        test_max_size();
        test_random();
        test_ignore_during_busy();
        test_reset_abort();
        test_load_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
